// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: FSM encodings, default
// image geometry and the RGB444 field layout of a frame-buffer word.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_WAIT_LINE  = 3'd2,
        ST_BYTE1      = 3'd3,
        ST_BYTE2      = 3'd4
    } cam_state_t;

    localparam int IMG_W_DEF = 160;
    localparam int IMG_H_DEF = 120;

    localparam int RGB444_W = 12;
    localparam int CH_W     = 4;
    localparam int R_LSB    = 8;
    localparam int G_LSB    = 4;
    localparam int B_LSB    = 0;

endpackage

// File: rtl/rgb565_to_rgb444.sv
// Packs one RGB565 pixel, delivered as two camera bytes, into an RGB444 word.
module rgb565_to_rgb444
    import cam_pkg::*;
(
    input  logic [7:0]          byte1_i,
    input  logic [7:0]          byte2_i,
    output logic [RGB444_W-1:0] pix_o
);

    // Low bits of each RGB565 channel are simply truncated.
    logic unused_bits;
    assign unused_bits = ^{byte1_i[3], byte2_i[6:5], byte2_i[0]};

    always_comb begin
        pix_o                 = '0;
        pix_o[R_LSB +: CH_W]  = byte1_i[7:4];
        pix_o[G_LSB +: CH_W]  = {byte1_i[2:0], byte2_i[7]};
        pix_o[B_LSB +: CH_W]  = byte2_i[4:1];
    end

endmodule

// File: rtl/cam_capture_rgb444.sv
// Camera pixel-clock capture: frames RGB565 bytes by VSYNC/HREF and writes
// RGB444 pixels into a frame buffer at row*IMG_W+col.
module cam_capture_rgb444
    import cam_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int AW    = 15,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_VSYNC,
    input  logic          CAM_HREF,
    input  logic [7:0]    CAM_px_data,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic          frame_done,
    output logic [2:0]    state
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);

    logic             vsync_q, vsync_d;
    logic             vsync_prev_q, vsync_prev_d;
    logic             href_q, href_d;
    logic [7:0]       px_q, px_d;
    cam_state_t       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [7:0]       byte1_q, byte1_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    data_q, data_d;
    logic             done_q, done_d;

    logic                vsync_rise;
    logic                vsync_fall;
    logic                pix_in_frame;
    logic [AW-1:0]       pix_addr;
    logic [RGB444_W-1:0] pix_rgb;

    rgb565_to_rgb444 u_conv (
        .byte1_i (byte1_q),
        .byte2_i (px_q),
        .pix_o   (pix_rgb)
    );

    assign vsync_rise   = vsync_q & ~vsync_prev_q;
    assign vsync_fall   = ~vsync_q & vsync_prev_q;
    assign pix_in_frame = (col_q < COL_W'(IMG_W)) && (row_q < ROW_W'(IMG_H));
    assign pix_addr     = AW'(row_q) * AW'(IMG_W) + AW'(col_q);

    // NOTE: every signal gets a default before any branch so that no path
    // leaves a combinational output unassigned, which would infer a latch.
    always_comb begin
        vsync_d      = CAM_VSYNC;
        vsync_prev_d = vsync_q;
        href_d       = CAM_HREF;
        px_d         = CAM_px_data;
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        byte1_d      = byte1_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        done_d       = vsync_rise && (row_q == ROW_W'(IMG_H));

        if (state_q != ST_IDLE && vsync_q) begin
            // Vertical blanking outside IDLE restarts the frame from the top.
            state_d = ST_WAIT_FRAME;
            col_d   = '0;
            row_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (vsync_q) state_d = ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (vsync_fall) state_d = ST_WAIT_LINE;
                end
                ST_WAIT_LINE: begin
                    if (href_q) begin
                        byte1_d = px_q;
                        state_d = ST_BYTE1;
                    end
                end
                ST_BYTE1: begin
                    if (href_q) begin
                        state_d = ST_BYTE2;
                        if (pix_in_frame) begin
                            we_d   = 1'b1;
                            addr_d = pix_addr;
                            data_d = DW'(pix_rgb);
                            col_d  = col_q + 1'b1;
                        end
                    end else begin
                        // Line ended on a lone byte1; that half pixel is dropped.
                        state_d = ST_WAIT_LINE;
                        col_d   = '0;
                        if (row_q < ROW_W'(IMG_H)) row_d = row_q + 1'b1;
                    end
                end
                ST_BYTE2: begin
                    if (href_q) begin
                        byte1_d = px_q;
                        state_d = ST_BYTE1;
                    end else begin
                        state_d = ST_WAIT_LINE;
                        col_d   = '0;
                        if (row_q < ROW_W'(IMG_H)) row_d = row_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_q       <= 1'b0;
            px_q         <= '0;
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            byte1_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            vsync_q      <= vsync_d;
            vsync_prev_q <= vsync_prev_d;
            href_q       <= href_d;
            px_q         <= px_d;
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            byte1_q      <= byte1_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            done_q       <= done_d;
        end
    end

    assign DP_RAM_addr_in = addr_q;
    assign DP_RAM_data_in = data_q;
    assign DP_RAM_regW    = we_q;
    assign frame_done     = done_q;
    assign state          = state_q;

endmodule

// File: doc/cam_capture_rgb444.md
CAM_CAPTURE_RGB444 -- requirements
Module: cam_capture_rgb444

Interface
REQ-001 Parameter IMG_W, default 160, pixels per captured line.
REQ-002 Parameter IMG_H, default 120, lines per captured frame.
REQ-003 Parameter AW, default 15, write-address width.
REQ-004 Parameter DW, default 12, write-data width (RGB444).
REQ-005 clk  in  1  camera pixel clock (CAM_PCLK domain); all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 CAM_VSYNC  in  1  frame sync; high = vertical blanking.
REQ-008 CAM_HREF  in  1  line valid; high = bytes on CAM_px_data are pixel data.
REQ-009 CAM_px_data  in  8  RGB565 byte stream, two bytes per pixel.
REQ-010 DP_RAM_addr_in  out  AW  frame-buffer write address, row*IMG_W+col.
REQ-011 DP_RAM_data_in  out  DW  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
REQ-012 DP_RAM_regW  out  1  one-cycle write strobe.
REQ-013 frame_done  out  1  one-cycle pulse at end of a complete frame.
REQ-014 state  out  3  current FSM state encoding, debug only.

Function
REQ-015 All inputs SHALL be registered once on rising clk before use; latency figures count from that register.
REQ-016 FSM states SHALL be IDLE(0), WAIT_FRAME(1), WAIT_LINE(2), BYTE1(3), BYTE2(4).
REQ-017 IDLE -> WAIT_FRAME when registered VSYNC=1; WAIT_FRAME -> WAIT_LINE on VSYNC 1->0 edge.
REQ-018 WAIT_LINE -> BYTE1 on first cycle with HREF=1; that cycle's byte SHALL be captured as byte1.
REQ-019 BYTE1 -> BYTE2 capturing byte2 when HREF=1; BYTE2 -> BYTE1 capturing next byte1 when HREF=1.
REQ-020 Conversion: R=byte1[7:4], G={byte1[2:0],byte2[7]}, B=byte2[4:1].
REQ-021 On each byte2 capture with col<IMG_W and row<IMG_H, DP_RAM_regW SHALL be 1 in the next cycle, with DP_RAM_addr_in=row*IMG_W+col and DP_RAM_data_in per REQ-020; col then increments.
REQ-022 Pixels with col>=IMG_W SHALL be dropped (no strobe); col saturates at IMG_W.
REQ-023 HREF 1->0 in BYTE1 or BYTE2 SHALL end the line: row increments, col clears, state -> WAIT_LINE; an odd trailing byte1 SHALL be discarded.
REQ-024 Short lines SHALL not shift the next line: each line starts at row*IMG_W.
REQ-025 When row reaches IMG_H, further lines SHALL produce no strobes until next frame.
REQ-026 VSYNC=1 in any state except IDLE SHALL abort the frame: col,row clear, state -> WAIT_FRAME, no strobe that cycle.
REQ-027 frame_done SHALL pulse one cycle on VSYNC rising edge iff row==IMG_H (all lines received).
REQ-028 HREF=1 while in WAIT_FRAME SHALL be ignored.
REQ-029 Address arithmetic SHALL use AW bits; IMG_W*IMG_H-1 (19199) SHALL fit without wrap.

Reset
REQ-030 On rst: state=IDLE, col=0, row=0, DP_RAM_regW=0, DP_RAM_addr_in=0, DP_RAM_data_in=0, frame_done=0, input registers=0.
REQ-031 rst asserted mid-line SHALL abort immediately; after release capture resumes only after a full VSYNC high->low sequence.

Structure
REQ-032 State encodings, IMG_W/IMG_H defaults and RGB444 field positions SHALL live in shared package cam_pkg.
REQ-033 RGB565->RGB444 packing SHALL be sub-module rgb565_to_rgb444 (combinational); FSM, counters and output registers remain in cam_capture_rgb444.

Verification
REQ-034 Bytes 0xF0,0x0F at row 0 col 0 -> one strobe, addr 0, data 0xF07.
REQ-035 Full 160x120 frame, 320 bytes/line, 4-line blanking -> 19200 strobes, last addr 19199, frame_done one pulse at next VSYNC rise.
REQ-036 Line of 330 bytes -> exactly 160 strobes; next line first addr = 160.
REQ-037 Line of 101 bytes at row 2 -> 50 strobes (addr 320..369), odd byte dropped; row 3 starts at addr 480.
REQ-038 VSYNC raised at row 60 -> no further strobes, no frame_done; next frame restarts at addr 0.
REQ-039 rst pulsed mid-line -> all outputs 0 within same cycle, no strobes until after VSYNC high->low.
